// File: rtl/mc_alu_pkg.sv
// rtl/mc_alu_pkg.sv - opcodes, FSM states and flag indices shared by mc_alu
package mc_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_DBZ   = 3;
  localparam int NFLAGS     = 4;

endpackage

// File: rtl/mc_alu_muldiv.sv
// rtl/mc_alu_muldiv.sv - one-bit-per-cycle shift-add multiplier / restoring divider
// The divide step exists only when MC_ALU_DIV_EN is defined.
module mc_alu_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             run;
  logic             is_div;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [WIDTH:0]   add_s;
`ifdef MC_ALU_DIV_EN
  logic [WIDTH:0]   shl, trial;
`endif

  // hi/lo carry the post-step value so the top can latch the final step on its own edge
  always_comb begin
    add_s = {1'b0, hi_q} + {1'b0, opnd_q};
    hi    = hi_q;
    lo    = lo_q;
`ifdef MC_ALU_DIV_EN
    shl   = {hi_q, lo_q[WIDTH-1]};
    trial = shl - {1'b0, opnd_q};
`endif
    if (is_div) begin
`ifdef MC_ALU_DIV_EN
      if (!trial[WIDTH]) begin
        hi = trial[WIDTH-1:0];
        lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi = shl[WIDTH-1:0];
        lo = {lo_q[WIDTH-2:0], 1'b0};
      end
`endif
    end else if (lo_q[0]) begin
      {hi, lo} = {add_s, lo_q[WIDTH-1:1]};
    end else begin
      {hi, lo} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end
  end

  assign done = run && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      run    <= 1'b0;
      is_div <= 1'b0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (start) begin
      run    <= 1'b1;
      is_div <= op_div;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= op_div ? a : b;
      opnd_q <= op_div ? b : a;
    end else if (run) begin
      hi_q <= hi;
      lo_q <= lo;
      cnt  <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU: single-cycle add/logic ops, iterative MUL/DIV
// Define MC_ALU_DIV_EN to build the iterative divider; otherwise opcode 101 yields zero.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  state_t            state;
  logic [NFLAGS-1:0] flags;
  logic              run_mul;
  logic [WIDTH:0]    sum, diff;
  logic [WIDTH-1:0]  sc_res, sc_hi;
  logic              sc_carry, sc_ovf, sc_dbz;
  logic              iter_op, md_start, md_done;
  logic [WIDTH-1:0]  md_hi, md_lo;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

`ifdef MC_ALU_DIV_EN
  // divide by zero short-circuits to the single-cycle path
  assign iter_op = (ALUControl == OP_MUL) || ((ALUControl == OP_DIV) && (B != '0));
`else
  assign iter_op = (ALUControl == OP_MUL);
`endif

  assign md_start = (state == S_IDLE) && start && iter_op;

  always_comb begin
    sc_res   = '0;
    sc_hi    = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dbz   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_XOR: sc_res = A ^ B;
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
`ifdef MC_ALU_DIV_EN
      OP_DIV: begin
        sc_res = '1;
        sc_hi  = A;
        sc_dbz = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  mc_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op_div (ALUControl == OP_DIV),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      Result   <= '0;
      ResultHi <= '0;
      flags    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      run_mul  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          busy    <= 1'b1;
          run_mul <= (ALUControl == OP_MUL);
          if (iter_op) begin
            state <= S_RUN;
          end else begin
            state             <= S_DONE;
            done              <= 1'b1;
            Result            <= sc_res;
            ResultHi          <= sc_hi;
            flags[FLAG_ZERO]  <= (sc_res == '0);
            flags[FLAG_CARRY] <= sc_carry;
            flags[FLAG_OVF]   <= sc_ovf;
            flags[FLAG_DBZ]   <= sc_dbz;
          end
        end
        S_RUN: if (md_done) begin
          state             <= S_DONE;
          done              <= 1'b1;
          Result            <= md_lo;
          ResultHi          <= md_hi;
          flags[FLAG_ZERO]  <= (md_lo == '0);
          flags[FLAG_CARRY] <= 1'b0;
          flags[FLAG_OVF]   <= run_mul && (md_hi != '0);
          flags[FLAG_DBZ]   <= 1'b0;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign zero        = flags[FLAG_ZERO];
  assign carry       = flags[FLAG_CARRY];
  assign overflow    = flags[FLAG_OVF];
  assign div_by_zero = flags[FLAG_DBZ];

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 8..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request; accepted when start=1 and busy=0.
REQ-005 SHALL have port A  input  WIDTH  operand A, sampled at accept.
REQ-006 SHALL have port B  input  WIDTH  operand B, sampled at accept.
REQ-007 SHALL have port ALUControl  input  3  opcode, sampled at accept.
REQ-008 SHALL have port Result  output  WIDTH  primary result (low product, quotient).
REQ-009 SHALL have port ResultHi  output  WIDTH  high product half / remainder; 0 for other ops.
REQ-010 SHALL have port busy  output  1  operation in progress; start ignored.
REQ-011 SHALL have port done  output  1  one-cycle pulse; Result/ResultHi/flags valid.
REQ-012 SHALL have ports zero, carry, overflow, div_by_zero  output  1 each  status flags.

Function
REQ-013 SHALL decode opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL (unsigned), 101 DIV (unsigned), 110 XOR, 111 SLT (signed, Result=1/0).
REQ-014 SHALL implement FSM IDLE -> (single-cycle op) DONE, IDLE -> (MUL/DIV) RUN -> DONE, DONE -> IDLE.
REQ-015 SHALL register the single-cycle-op result on the accept edge; done=1 in the following cycle (latency 1).
REQ-016 SHALL compute MUL by shift-add and DIV by restoring division, one bit per cycle, WIDTH RUN cycles; done asserted WIDTH+1 cycles after accept.
REQ-017 SHALL assert busy in RUN and DONE; busy=0 in IDLE, so a new start is accepted in the cycle after done.
REQ-018 SHALL ignore start while busy=1 without disturbing captured operands or count.
REQ-019 SHALL hold Result, ResultHi and flags stable from done until the next accept.
REQ-020 SHALL set carry = carry-out for ADD, borrow for SUB (A<B unsigned), 0 otherwise.
REQ-021 SHALL set overflow = signed two's-complement overflow for ADD/SUB; for MUL, overflow=1 iff ResultHi!=0; 0 otherwise.
REQ-022 SHALL set zero=1 iff Result==0 (all ops).
REQ-023 SHALL, for DIV with B==0, complete in 1 cycle with Result=all-ones, ResultHi=A, div_by_zero=1; div_by_zero=0 for all other cases.
REQ-024 SHALL keep the iteration counter width $clog2(WIDTH)+1 with no wrap before WIDTH.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter IDLE and clear Result, ResultHi, all flags, busy, done and the counter.
REQ-026 SHALL abort any in-flight MUL/DIV on reset mid-operation; no done pulse for it.
REQ-027 SHALL give rst priority over start in the same cycle.

Configuration
REQ-028 SHALL compile the iterative DIV datapath only when macro MC_ALU_DIV_EN is defined.
REQ-029 SHALL, without MC_ALU_DIV_EN, treat opcode 101 as single-cycle with Result=0, ResultHi=0, div_by_zero=0, zero=1.

Structure
REQ-030 SHALL place opcode localparams, FSM state encoding and flag-index constants in package mc_alu_pkg.
REQ-031 SHALL implement the shift-add/restoring datapath in sub-module mc_alu_muldiv (start, op, operands in; done, hi/lo out); add/logic ops stay in mc_alu.

Verification
REQ-032 SHALL cover ADD: A=11,B=3 -> Result=14, done one cycle after accept, flags 0.
REQ-033 SHALL cover ADD overflow: A=16'h7FFF,B=1 -> Result=16'h8000, overflow=1, carry=0; SUB A=3,B=10 -> Result=16'hFFF9, carry=1.
REQ-034 SHALL cover MUL: A=12,B=10 -> Result=120, ResultHi=0, done 17 cycles after accept; A=B=16'hFFFF -> ResultHi=16'hFFFE, Result=1, overflow=1.
REQ-035 SHALL cover DIV: A=120,B=10 -> Result=12, ResultHi=0; A=7,B=0 -> Result=16'hFFFF, ResultHi=7, div_by_zero=1, latency 1.
REQ-036 SHALL cover start pulsed mid-MUL (ignored, result unchanged) and rst asserted at RUN cycle 5 -> IDLE, all outputs 0, no done.
REQ-037 SHALL rerun REQ-032..035 at WIDTH=32 and with MC_ALU_DIV_EN undefined (opcode 101 -> Result=0, zero=1).
